muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
Sequencer for the R-type multiply/divide group and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage and runs an iterative 32-step shift-add multiply or restoring divide. It owns HI/LO and stalls the pipeline when an instruction needs HI/LO while an operation is still in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; the step counter is $clog2(DATA_W) bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid  in  1  execute-stage instruction is R-type and presented this cycle
- funct  in  6  R-type funct field
- rs_val  in  DATA_W  rs operand (dividend / multiplicand / MTxx source)
- rt_val  in  DATA_W  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush; aborts in-flight op
- stall  out  1  hold execute stage this cycle
- busy  out  1  mult/div in progress
- result  out  DATA_W  MFHI/MFLO read data
- hi  out  DATA_W  architectural HI
- lo  out  DATA_W  architectural LO

Behaviour:
- Funct decode: MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULT=24, MULTU=25, DIV=26, DIVU=27. Any other funct: ignored, no stall.
- Reset (async, rst_n=0): state=IDLE, hi=lo=0, counter=0, busy=0, stall=0, result=0. Reset mid-operation discards the operation.
- stall is combinational: valid & !flush & busy & funct in {MFHI,MFLO,MTHI,MTLO,MULT,MULTU,DIV,DIVU}. Accept = valid & !flush & !stall & recognised funct.
- MFHI/MFLO: result = hi/lo combinationally in the accept cycle. Otherwise result = 0.
- MTHI/MTLO: hi/lo <= rs_val at the edge ending the accept cycle.
- FSM states:
  - IDLE: on an accepted MULT/MULTU/DIV/DIVU, latch operands and go to RUN.
    - Signed ops latch absolute values plus sign flags: neg_q = sign(rs)^sign(rt), neg_r = sign(rs).
    - DIV/DIVU with rt_val=0 skips RUN and goes to FIX with HI=rs_val, LO=all-ones.
  - RUN: exactly DATA_W cycles, counter 0..DATA_W-1.
    - Multiply: 2*DATA_W-bit shift-add.
    - Divide: restoring, one quotient bit per cycle.
    - After the last step, go to FIX.
  - FIX: apply sign correction, write hi/lo at the edge ending FIX, then go to IDLE.
    - Multiply: negate the 64-bit product if neg_q.
    - Divide: negate quotient if neg_q, negate remainder if neg_r.
- Register mapping: multiply HI=product[63:32], LO=product[31:0]; divide LO=quotient, HI=remainder.
- Overflow/wrap: signed -2^31 / -1 gives LO=0x80000000, HI=0 (two's-complement wrap, no trap). |-2^31| is handled as unsigned 0x80000000.
- Timing: accept at cycle T → busy=1 in cycles T+1..T+33 (32 RUN + 1 FIX) → hi/lo valid and busy=0 in cycle T+34. Divide-by-zero: busy=1 in T+1 only; result visible in T+2.
- A dependent MFxx/MTxx/mult/div presented while busy holds stall=1 every cycle and is accepted in the first cycle busy=0.
- flush: any state → IDLE at the next edge. hi/lo unchanged, operation discarded. flush with valid in the same cycle: flush wins, nothing accepted, stall=0.
- Independent instructions (unrecognised funct or valid=0) never stall while busy.

Test Plan:
- After reset, MULT rs=0xFFFFFFFD (-3), rt=5 → busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy=0 at T+34.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 9/0 → busy 1 cycle, then HI=9, LO=0xFFFFFFFF.
- MULT 6*7, then MFLO presented at T+2 and held → stall=1 through T+33, result=42 with stall=0 at T+34. An unrecognised funct at T+5 → stall=0.
- MTLO 0x1234 (lo=0x1234), then DIVU 50/3, flush at T+10 → IDLE at T+11, busy=0, lo stays 0x1234. A separate run: rst_n pulsed low at T+10 → hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner and iterative multiply/divide sequencer.
// Stalls dependent HI/LO users while a 32-step operation is in flight.
module muldiv_hilo_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = $clog2(DATA_W);

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
    logic              op_div, neg_q, neg_r;

    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic is_mul, is_div, is_sgn, is_md, recog;
    logic accept, div_zero;

    assign is_mfhi = (funct == F_MFHI);
    assign is_mflo = (funct == F_MFLO);
    assign is_mthi = (funct == F_MTHI);
    assign is_mtlo = (funct == F_MTLO);
    assign is_mul  = (funct == F_MULT) | (funct == F_MULTU);
    assign is_div  = (funct == F_DIV) | (funct == F_DIVU);
    assign is_sgn  = (funct == F_MULT) | (funct == F_DIV);
    assign is_md   = is_mul | is_div;
    assign recog   = is_mfhi | is_mflo | is_mthi | is_mtlo | is_md;

    assign busy     = (state != S_IDLE);
    assign stall    = valid & ~flush & busy & recog;
    assign accept   = valid & ~flush & ~stall & recog;
    assign div_zero = is_div & (rt_val == '0);

    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_abs, rt_abs;

    assign rs_neg = is_sgn & rs_val[DATA_W-1];
    assign rt_neg = is_sgn & rt_val[DATA_W-1];
    assign rs_abs = rs_neg ? -rs_val : rs_val;
    assign rt_abs = rt_neg ? -rt_val : rt_val;

    logic [DATA_W:0]     mul_sum, div_sh;
    logic [DATA_W-1:0]   mul_hi_n, mul_lo_n;
    logic [DATA_W-1:0]   div_sub, div_hi_n, div_lo_n;
    logic                div_ge;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // One shift-add / restoring-divide step plus final sign correction
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_n = mul_sum[DATA_W:1];
        mul_lo_n = {mul_sum[0], acc_lo[DATA_W-1:1]};
        div_sh   = {acc_hi, acc_lo[DATA_W-1]};
        div_ge   = (div_sh >= {1'b0, opnd});
        div_sub  = div_sh[DATA_W-1:0] - opnd;
        div_hi_n = div_ge ? div_sub : div_sh[DATA_W-1:0];
        div_lo_n = {acc_lo[DATA_W-2:0], div_ge};
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    // MFHI/MFLO read data, only in the accept cycle
    always_comb begin
        result = '0;
        if (accept && is_mfhi) result = hi;
        if (accept && is_mflo) result = lo;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept && is_md) state_n = div_zero ? S_FIX : S_RUN;
            S_RUN:  if (cnt == CW'(DATA_W - 1)) state_n = S_FIX;
            S_FIX:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    // Datapath: operand latch, iteration, HI/LO writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_mthi: hi <= rs_val;
                            is_mtlo: lo <= rs_val;
                            is_md: begin
                                cnt    <= '0;
                                op_div <= is_div;
                                if (div_zero) begin
                                    acc_hi <= rs_val;
                                    acc_lo <= '1;
                                    neg_q  <= 1'b0;
                                    neg_r  <= 1'b0;
                                end else begin
                                    acc_hi <= '0;
                                    acc_lo <= is_div ? rs_abs : rt_abs;
                                    opnd   <= is_div ? rt_abs : rs_abs;
                                    neg_q  <= rs_neg ^ rt_neg;
                                    neg_r  <= rs_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= op_div ? div_hi_n : mul_hi_n;
                    acc_lo <= op_div ? div_lo_n : mul_lo_n;
                end
                S_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl.
// Driver pushes model results; monitor pops on DUT output events.
module tb_muldiv_hilo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall, busy;
    logic [31:0] result, hi, lo;

    muldiv_hilo_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .stall(stall), .busy(busy), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // kind: 0 = op completion (hi/lo + busy length), 1 = MFxx result, 2 = MTxx write
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          dur;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit recog(input logic [5:0] f);
        return (f >= 6'd16 && f <= 6'd19) || (f >= 6'd24 && f <= 6'd27);
    endfunction

    // Architectural reference: applies the instruction in program order
    task automatic model(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        longint      x, y, q, r;
        logic [63:0] p;
        exp_t        e;
        e.kind = 0; e.a = '0; e.b = '0; e.dur = 33;
        case (f)
            6'd16: begin e.kind = 1; e.a = m_hi; sb.push_back(e); end
            6'd18: begin e.kind = 1; e.a = m_lo; sb.push_back(e); end
            6'd17: begin m_hi = a; e.kind = 2; e.a = m_hi; e.b = m_lo; sb.push_back(e); end
            6'd19: begin m_lo = a; e.kind = 2; e.a = m_hi; e.b = m_lo; sb.push_back(e); end
            6'd24, 6'd25: begin
                if (f == 6'd24) begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    p = 64'(x * y);
                end else begin
                    p = {32'd0, a} * {32'd0, b};
                end
                m_hi = p[63:32]; m_lo = p[31:0];
                e.a = m_hi; e.b = m_lo; sb.push_back(e);
            end
            6'd26, 6'd27: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; e.dur = 1;
                end else if (f == 6'd26) begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    q = x / y;
                    r = x % y;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                e.a = m_hi; e.b = m_lo; sb.push_back(e);
            end
            default: ;
        endcase
    endtask

    // Present one instruction and hold it until accepted
    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit track = 1'b1);
        bit done = 1'b0;
        valid = 1'b1; funct = f; rs_val = a; rt_val = b;
        if (track) model(f, a, b);
        if (recog(f)) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!stall) begin done = 1'b1; break; end
            end
            if (!done) begin
                n_total++;
                $display("FAIL issue_timeout: funct %0d still stalled", f);
            end
        end else begin
            @(negedge clk);
            check("stall_indep", {31'd0, stall}, 32'd0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    int   bcnt = 0;
    bit   prev_busy = 1'b0;
    bit   prev_flush = 1'b0;
    bit   mt_pend = 1'b0;

    task automatic pop(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
        else begin
            n_total++;
            $display("FAIL sb_empty: DUT output with no expected entry at %0t", $time);
        end
    endtask

    // Monitor: completions, MTxx writes and MFxx reads
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst_n) begin
            bcnt = 0; prev_busy = 1'b0; prev_flush = 1'b0; mt_pend = 1'b0;
        end else begin
            if (busy) bcnt++;
            else begin
                if (prev_busy && !prev_flush) begin
                    pop(e, ok);
                    if (ok) begin
                        check("op_hi", hi, e.a);
                        check("op_lo", lo, e.b);
                        check("op_busy_len", bcnt, e.dur);
                    end
                end
                bcnt = 0;
            end
            if (mt_pend) begin
                pop(e, ok);
                if (ok) begin
                    check("mt_hi", hi, e.a);
                    check("mt_lo", lo, e.b);
                end
                mt_pend = 1'b0;
            end
            if (valid && !flush && !stall && (funct == 6'd16 || funct == 6'd18)) begin
                pop(e, ok);
                if (ok) check("mf_result", result, e.a);
            end
            if (valid && !flush && !stall && (funct == 6'd17 || funct == 6'd19))
                mt_pend = 1'b1;
            prev_busy = busy;
            prev_flush = flush;
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
        return $urandom;
    endfunction

    initial begin
        logic [5:0] ftab [10] = '{6'd16, 6'd17, 6'd18, 6'd19, 6'd24,
                                  6'd25, 6'd26, 6'd27, 6'd0, 6'd32};
        int n;
        bit done;

        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(6'd24, 32'hFFFF_FFFD, 32'd5);
        issue(6'd16, 0, 0);
        issue(6'd18, 0, 0);
        issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(6'd27, 32'd100, 32'd7);
        issue(6'd26, 32'hFFFF_FFF9, 32'd2);
        issue(6'd18, 0, 0);
        issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(6'd26, 32'd9, 32'd0);
        issue(6'd16, 0, 0);

        // Dependent MFLO held behind a multiply
        issue(6'd24, 32'd6, 32'd7);
        @(posedge clk); #1;
        valid = 1'b1; funct = 6'd18;
        model(6'd18, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("stall_dep", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        funct = 6'd0;
        @(negedge clk);
        check("stall_unrec", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        funct = 6'd18;
        n = 0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) begin done = 1'b1; break; end
            n++;
        end
        check("stall_cycles", 32'(n), 32'd28);
        @(posedge clk); #1;
        valid = 1'b0;

        // Flush aborts a divide
        issue(6'd19, 32'h1234, 0);
        issue(6'd27, 32'd50, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; valid = 1'b1; funct = 6'd18;
        @(negedge clk);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_lo", lo, 32'h1234);
        check("flush_hi", hi, m_hi);
        repeat (40) @(posedge clk);
        #1;
        check("flush_lo_late", lo, 32'h1234);

        // Async reset mid-multiply
        issue(6'd17, 32'hA5A5_0001, 0);
        issue(6'd24, 32'd1234, 32'd5678, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_hi_late", hi, 32'd0);
        check("arst_lo_late", lo, 32'd0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(ftab[$urandom_range(0, 9)], pick(), pick());
        end

        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && !busy) begin done = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
